uart_rx: RTL

- UART receiver; sits directly downstream of the UART transmitter on the serial line, either at the far end of a link or in loopback.
- Recovers frames of the form: start bit (0), FRAME_WIDTH data bits LSB-first, one stop bit (1). Bit time is BAUD_PERIOD+1 clk cycles, matching the transmitter's shift cadence.
- Presents each received word with a sticky ready flag plus framing-error and overrun status for a memory/CPU-side consumer.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 30 +++
 rtl/uart_rx.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// UART receiver shared types and helpers.
// State encoding and counter sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int baud_w(input int bp);
    return $clog2(bp + 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the async serial line.
// Adds one delay flop so a falling edge can be flagged.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic i_d,
  output logic o_q,
  output logic o_fall
);

  logic [N-1:0] r_sync;
  logic         r_dly;

  // Shift the line through the sync chain; idle level is high.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sync <= '1;
      r_dly  <= 1'b1;
    end else begin
      r_sync <= {r_sync[N-2:0], i_d};
      r_dly  <= r_sync[N-1];
    end
  end

  assign o_q    = r_sync[N-1];
  assign o_fall = ~r_sync[N-1] & r_dly;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, LSB-first data, one stop bit.
// Sticky ready with framing-error and overrun status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int BAUD_PERIOD = 15
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   rx,
  input  logic                   clr_rdy,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   rdy,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int BW = baud_w(BAUD_PERIOD);
  localparam int CW = $clog2(FRAME_WIDTH) + 1;
  localparam logic [BW-1:0] START_T  = BW'(BAUD_PERIOD / 2);
  localparam logic [BW-1:0] BIT_T    = BW'(BAUD_PERIOD);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_WIDTH - 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [BW-1:0]          r_baud;
  logic [CW-1:0]          r_bit_cnt;
  logic [FRAME_WIDTH-1:0] r_shift;
  logic [FRAME_WIDTH-1:0] r_rx_data;
  logic                   r_rdy;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic          w_rx_s;
  logic          w_fall;
  logic [BW-1:0] w_target;
  logic          w_sample;
  logic          w_done;

  uart_sync #(.N(2)) u_sync (
    .clk    (clk),
    .rst_l  (rst_l),
    .i_d    (rx),
    .o_q    (w_rx_s),
    .o_fall (w_fall)
  );

  assign w_target = (r_state == START) ? START_T : BIT_T;
  assign w_sample = (r_state != IDLE) && (r_baud == w_target);
  assign w_done   = (r_state == STOP) && w_sample;

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: edge-triggered start, mid-bit checks after that.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_fall) w_state_nxt = START;
      START: if (w_sample) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA:  if (w_sample && (r_bit_cnt == LAST_BIT)) w_state_nxt = STOP;
      STOP:  if (w_sample) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit timing, bit counting and the LSB-first shift register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == IDLE || w_sample) r_baud <= '0;
      else                             r_baud <= r_baud + 1'b1;
      if (r_state == IDLE && w_fall)
        r_bit_cnt <= '0;
      else if (r_state == DATA && w_sample)
        r_bit_cnt <= r_bit_cnt + 1'b1;
      if (r_state == DATA && w_sample)
        r_shift <= {w_rx_s, r_shift[FRAME_WIDTH-1:1]};
    end
  end

  // Consumer-visible word and flags; completion beats an ack.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rx_data   <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_done) begin
      r_rx_data   <= r_shift;
      r_rdy       <= 1'b1;
      r_frame_err <= ~w_rx_s;
      r_overrun   <= clr_rdy ? 1'b0 : (r_overrun | r_rdy);
    end else if (clr_rdy) begin
      r_rdy     <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rdy       = r_rdy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
